// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op codes,
// controller states and the default iteration count.
package muldiv_pkg;

  localparam int MD_ITERS = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } md_state_t;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate; shared by operand magnitude
// extraction and by the sign fix-up of finished results.
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? ((~a) + W'(1)) : a;

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: one bit per cycle on
// unsigned magnitudes, sign fix-up in FIX, commit to HI/LO on leaving FIX.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_ITERS
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             cancel,
  input  logic             hilo_read,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             stall
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  md_state_t          state_reg, state_next;
  logic               accept;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] acc_reg, acc_step;
  logic [WIDTH-1:0]   mcand_reg;
  logic               is_div_reg, neg_q_reg, neg_r_reg, dz_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;

  // Operand decode and magnitude extraction at load time
  logic             op_div, op_signed;
  logic [WIDTH-1:0] rs_mag, rt_mag;

  assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);

  muldiv_negate #(.W(WIDTH)) u_neg_rs (
    .a(rs_data), .neg(op_signed & rs_data[WIDTH-1]), .y(rs_mag)
  );
  muldiv_negate #(.W(WIDTH)) u_neg_rt (
    .a(rt_data), .neg(op_signed & rt_data[WIDTH-1]), .y(rt_mag)
  );

  // Iteration step: acc holds {partial, multiplier} for mul and
  // {remainder, dividend/quotient} for div.
  logic [WIDTH:0] mul_sum, div_shift, div_diff;

  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, (acc_reg[0] ? mcand_reg : '0)};
    div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand_reg};
    acc_step  = {mul_sum, acc_reg[WIDTH-1:1]};
    if (is_div_reg) begin
      if (!div_diff[WIDTH])
        acc_step = {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
      else
        acc_step = {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
    end
  end

  // Result sign fix-up
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, hi_commit, lo_commit;

  muldiv_negate #(.W(2*WIDTH)) u_neg_prod (
    .a(acc_reg), .neg(neg_q_reg), .y(prod_fix)
  );
  muldiv_negate #(.W(WIDTH)) u_neg_quo (
    .a(acc_reg[WIDTH-1:0]), .neg(neg_q_reg), .y(quo_fix)
  );
  muldiv_negate #(.W(WIDTH)) u_neg_rem (
    .a(acc_reg[2*WIDTH-1:WIDTH]), .neg(neg_r_reg), .y(rem_fix)
  );

  assign hi_commit = is_div_reg ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign lo_commit = is_div_reg ? quo_fix : prod_fix[WIDTH-1:0];

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN:     if (cnt_reg == '0) state_next = FIX;
      FIX:     state_next = DONE;
      default: state_next = IDLE;
    endcase
    // A flush always wins, including over a same-cycle start
    if (cancel) begin
      accept     = 1'b0;
      state_next = IDLE;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      dz_reg     <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        cnt_reg    <= CW'(WIDTH - 1);
        acc_reg    <= {{WIDTH{1'b0}}, (op_div ? rs_mag : rt_mag)};
        mcand_reg  <= op_div ? rt_mag : rs_mag;
        is_div_reg <= op_div;
        neg_q_reg  <= op_signed & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
        neg_r_reg  <= op_signed & rs_data[WIDTH-1];
        dz_reg     <= (rt_data == '0);
      end else if (state_reg == RUN) begin
        acc_reg <= acc_step;
        if (cnt_reg != '0) cnt_reg <= cnt_reg - CW'(1);
      end

      if (state_reg == FIX) begin
        if (!cancel) begin
          hi_reg <= hi_commit;
          lo_reg <= lo_commit;
        end
      end else if (state_reg == IDLE || state_reg == DONE) begin
        if (hi_we) hi_reg <= wdata;
        if (lo_we) lo_reg <= wdata;
      end
    end
  end

  assign HI          = hi_reg;
  assign LO          = lo_reg;
  assign busy        = (state_reg == RUN) || (state_reg == FIX);
  assign done        = (state_reg == DONE);
  assign div_by_zero = (state_reg == DONE) && is_div_reg && dz_reg;
  assign stall       = busy & (start | hilo_read | hi_we | lo_we);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed and random operations
// against an arithmetic reference model, plus stall, MTLO, cancel and reset.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_data = '0, rt_data = '0, wdata = '0;
  logic        cancel = 1'b0, hilo_read = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [31:0] hi_o, lo_o;
  logic        busy, done, div_by_zero, stall;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_hi = '0, model_lo = '0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .Clk(clk), .Rst(rst), .start(start), .op(op), .rs_data(rs_data), .rt_data(rt_data),
    .cancel(cancel), .hilo_read(hilo_read), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .HI(hi_o), .LO(lo_o), .busy(busy), .done(done), .div_by_zero(div_by_zero), .stall(stall)
  );

  // Reference: plain 64-bit / int arithmetic
  task automatic ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] eh, output logic [31:0] el, output bit edz);
    logic [63:0] p;
    int sa, sb;
    edz = 1'b0;
    case (o)
      2'b00: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        eh = p[63:32]; el = p[31:0];
      end
      2'b01: begin
        p = {32'd0, a} * {32'd0, b};
        eh = p[63:32]; el = p[31:0];
      end
      2'b10: begin
        sa = a; sb = b;
        if (b == 0) begin
          edz = 1'b1; eh = a; el = a[31] ? 32'h1 : 32'hFFFFFFFF;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          eh = 32'h0; el = 32'h80000000;
        end else begin
          eh = sa % sb; el = sa / sb;
        end
      end
      default: begin
        if (b == 0) begin
          edz = 1'b1; eh = a; el = 32'hFFFFFFFF;
        end else begin
          eh = a % b; el = a / b;
        end
      end
    endcase
  endtask

  // Issues one operation and follows it through T+34 (ends in the done cycle)
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit wait_first, input int rd_from, input bit mt_lo,
                       input logic [31:0] mt_val);
    logic [31:0] eh, el;
    bit edz;
    int busy_n, done_n;
    ref_model(o, a, b, eh, el, edz);
    if (wait_first) @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(negedge clk);
    start = 1'b0;
    busy_n = 0; done_n = 0;
    for (int k = 1; k <= 34; k++) begin
      if (k > 1) @(negedge clk);
      if (rd_from != 0 && k == rd_from) begin
        hilo_read = !mt_lo; lo_we = mt_lo; wdata = mt_val;
      end
      #1;
      busy_n += int'(busy);
      done_n += int'(done);
      if (rd_from != 0 && k >= rd_from) begin
        checks++;
        if (stall !== (k <= 33)) begin
          errors++; $display("FAIL stall k=%0d: got %b want %b", k, stall, (k <= 33));
        end
      end
      if (k == 33) begin
        checks++;
        if (hi_o !== model_hi || lo_o !== model_lo) begin
          errors++; $display("FAIL early_commit: got %h_%h want %h_%h", hi_o, lo_o, model_hi, model_lo);
        end
      end
    end
    $display("op=%0d rs=%h rt=%h -> HI=%h LO=%h dz=%b (want %h %h %b)",
             o, a, b, hi_o, lo_o, div_by_zero, eh, el, edz);
    checks++;
    if (done !== 1'b1 || done_n != 1) begin
      errors++; $display("FAIL done_pulse: got done=%b pulses=%0d want 1 and 1", done, done_n);
    end
    checks++;
    if (busy_n != 33) begin
      errors++; $display("FAIL busy_len: got %0d want 33", busy_n);
    end
    checks++;
    if (hi_o !== eh) begin
      errors++; $display("FAIL hi_result: got %h want %h", hi_o, eh);
    end
    checks++;
    if (lo_o !== el) begin
      errors++; $display("FAIL lo_result: got %h want %h", lo_o, el);
    end
    checks++;
    if (div_by_zero !== edz) begin
      errors++; $display("FAIL div_by_zero: got %b want %b", div_by_zero, edz);
    end
    model_hi = eh; model_lo = el;
    if (mt_lo) begin
      @(negedge clk);
      lo_we = 1'b0;
      #1;
      checks++;
      if (lo_o !== mt_val || hi_o !== model_hi) begin
        errors++; $display("FAIL mtlo_after_busy: got %h_%h want %h_%h", hi_o, lo_o, model_hi, mt_val);
      end
      model_lo = mt_val;
    end
    hilo_read = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    hilo_read = 1'b1;
    #1;
    checks++;
    if (hi_o !== 0 || lo_o !== 0 || busy !== 0 || done !== 0 || div_by_zero !== 0 || stall !== 0) begin
      errors++; $display("FAIL reset_state: got HI=%h LO=%h b=%b d=%b z=%b s=%b want all 0",
                         hi_o, lo_o, busy, done, div_by_zero, stall);
    end
    hilo_read = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_directed;
    do_op(2'b00, 32'hFFFFFFFD, 32'd5, 1'b1, 0, 1'b0, '0);
    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0, 1'b0, '0);
    do_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b1, 0, 1'b0, '0);
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b1, 0, 1'b0, '0);
    do_op(2'b11, 32'd100, 32'd0, 1'b1, 0, 1'b0, '0);
    do_op(2'b10, 32'hFFFFFFFB, 32'd0, 1'b1, 0, 1'b0, '0);
  endtask

  task automatic test_stall_and_mtlo;
    do_op(2'b00, 32'd1234, 32'hFFFF0001, 1'b1, 5, 1'b0, '0);
    do_op(2'b11, 32'd77777, 32'd13, 1'b1, 5, 1'b1, 32'hA5A5_1234);
  endtask

  task automatic test_mthi_idle;
    logic [31:0] v;
    v = $urandom;
    @(negedge clk);
    hi_we = 1'b1; wdata = v;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    checks++;
    if (hi_o !== v || lo_o !== model_lo) begin
      errors++; $display("FAIL mthi_idle: got %h_%h want %h_%h", hi_o, lo_o, v, model_lo);
    end
    model_hi = v;
  endtask

  task automatic test_back_to_back;
    do_op(2'b01, 32'd3, 32'd7, 1'b1, 0, 1'b0, '0);
    do_op(2'b10, 32'd1000, 32'hFFFFFFFD, 1'b0, 0, 1'b0, '0);
    do_op(2'b00, 32'h7FFFFFFF, 32'h80000000, 1'b0, 0, 1'b0, '0);
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    int sel;
    for (int i = 0; i < 24; i++) begin
      a = $urandom; b = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = '0;
      else if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      else if (sel == 2) begin a = $urandom_range(0, 50); b = $urandom_range(1, 9); end
      do_op(2'($urandom_range(0, 3)), a, b, 1'b1, 0, 1'b0, '0);
    end
  endtask

  task automatic test_cancel;
    int done_n;
    @(negedge clk);
    start = 1'b1; op = 2'b00; rs_data = 32'h1234_5678; rt_data = 32'h9;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL cancel_idle: got busy=%b want 0", busy);
    end
    done_n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      done_n += int'(done);
    end
    checks++;
    if (done_n != 0 || hi_o !== model_hi || lo_o !== model_lo) begin
      errors++; $display("FAIL cancel_retain: got done=%0d %h_%h want 0 %h_%h",
                         done_n, hi_o, lo_o, model_hi, model_lo);
    end
    start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL cancel_beats_start: got busy=%b want 0", busy);
    end
    $display("cancel sequence: HI=%h LO=%h", hi_o, lo_o);
  endtask

  task automatic test_reset_midrun;
    @(negedge clk);
    start = 1'b1; op = 2'b11; rs_data = 32'd999; rt_data = 32'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    hilo_read = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (hi_o !== 0 || lo_o !== 0 || busy !== 0 || done !== 0 || div_by_zero !== 0 || stall !== 0) begin
      errors++; $display("FAIL reset_midrun: got HI=%h LO=%h b=%b d=%b z=%b s=%b want all 0",
                         hi_o, lo_o, busy, done, div_by_zero, stall);
    end
    hilo_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_hi = '0; model_lo = '0;
    $display("reset mid-run: HI=%h LO=%h busy=%b", hi_o, lo_o, busy);
    do_op(2'b00, 32'd6, 32'd7, 1'b1, 0, 1'b0, '0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mthi_idle();
    test_stall_and_mtlo();
    test_back_to_back();
    test_cancel();
    test_random();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
